// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and the future RX demux.
package uart_arb_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } arb_state_e;

    // Upper nibble of every channel-ID header byte.
    localparam logic [3:0] HDR_TAG = 4'hA;

    // Header byte announcing which channel the following burst belongs to.
    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping at N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_winner,
    output logic          o_any
);

    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    always_comb begin
        int idx;
        idx      = 0;
        o_winner = '0;
        o_any    = |i_req;
        for (int off = N - 1; off >= 0; off--) begin
            // Modulo keeps the index legal even when N is not a power of two.
            idx = (int'(i_ptr) + off) % N;
            if (i_req[idx]) begin
                o_winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit byte port among NUM_REQ byte streams with
// packet-level round-robin grants and an optional channel-ID header per burst.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 16,
    parameter  int HEADER_EN  = 1,
    localparam int PW         = $clog2(NUM_REQ),
    localparam int BW         = $clog2(MAX_BURST + 1)
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic [PW-1:0]                 o_grant_id,
    output logic                          o_busy
);

    arb_state_e                state_q, state_d;
    logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]             grant_q, grant_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;

    // Requester r's byte sits in element r, matching the flat r*DATA_WIDTH layout.
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    assign req_data = i_req_data;

    logic          slot_free;
    logic [PW-1:0] winner;
    logic          any_req;
    logic          gnt_valid;
    logic          gnt_last;
    logic          accept;
    logic          burst_end;
    logic [PW-1:0] next_ptr;

    // The single output slot can take a new byte when empty or being drained now.
    assign slot_free = !tx_valid_q || i_tx_ready;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req    (i_req_valid),
        .i_ptr    (rr_ptr_q),
        .o_winner (winner),
        .o_any    (any_req)
    );

    assign gnt_valid = i_req_valid[grant_q];
    assign gnt_last  = i_req_last[grant_q];
    assign accept    = (state_q == DATA) && slot_free && gnt_valid;
    // A burst closes on packet end or when the beat budget is spent.
    assign burst_end = gnt_last || (beat_q == BW'(MAX_BURST - 1));
    // Explicit wrap so non-power-of-two requester counts never point past the end.
    assign next_ptr  = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);

    // Only the granted lane sees ready, and only while bytes are flowing.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_ready
        assign o_req_ready[r] = (state_q == DATA) && (grant_q == PW'(r)) && slot_free;
    end

    // Next-state, grant bookkeeping and output-slot loading.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        // Draining with nothing new to load empties the slot; a load below overrides.
        if (tx_valid_q && i_tx_ready) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Arbitration does not wait for the slot; the previous byte may still drain.
                if (any_req) begin
                    grant_d = winner;
                    beat_d  = '0;
                    state_d = (HEADER_EN != 0) ? HEADER : DATA;
                end
            end
            HEADER: begin
                if (slot_free) begin
                    tx_data_d  = DATA_WIDTH'(hdr_byte(4'(grant_q)));
                    tx_valid_d = 1'b1;
                    state_d    = DATA;
                end
            end
            DATA: begin
                // A stalled requester keeps the grant indefinitely.
                if (accept) begin
                    tx_data_d  = req_data[grant_q];
                    tx_valid_d = 1'b1;
                    beat_d     = beat_q + BW'(1);
                    if (burst_end) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial packet.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != IDLE) || tx_valid_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte stream (UARTDriver io_uart_tx_data ready/valid port) among NUM_REQ byte-stream requesters: firmware console, DMA log, debug monitor.
- Round-robin arbitration with packet-level grant. Optionally prefixes each granted burst with a channel-ID header byte so the host side can demultiplex.
- Sits between the requesters and the UART transmit port, in the SoC and in the simulation UART transactor.

Parameters:
- NUM_REQ, 4, number of requesters, 2..16.
- DATA_WIDTH, 8, byte width of every data path.
- MAX_BURST, 16, maximum data beats per grant before forced re-arbitration, ≥1.
- HEADER_EN, 1, 1 = emit header byte {4'hA, grant_id[3:0]} before each burst.

Ports:
- i_clock  in  1  single clock for all logic.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  NUM_REQ  per-requester byte valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester r uses bits [r*8 +: 8].
- i_req_last  in  NUM_REQ  marks the final byte of a packet.
- o_req_ready  out  NUM_REQ  per-requester ready, one-hot or zero.
- o_tx_data  out  DATA_WIDTH  byte to the UART transmitter.
- o_tx_valid  out  1  byte valid to the UART transmitter.
- i_tx_ready  in  1  UART transmitter ready.
- o_grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- o_busy  out  1  high when state ≠ IDLE or o_tx_valid is high.

Behaviour:
- Reset (async assert, sync deassert is the integrator's duty):
  - State IDLE; rr_ptr=0; grant_id=0; beat_cnt=0.
  - o_tx_valid=0, o_tx_data=0, o_req_ready=0, o_busy=0.
  - Reset mid-burst abandons the partial packet; no header or data is replayed.
- Output register: one slot holding o_tx_data/o_tx_valid.
  - slot_free = !o_tx_valid || i_tx_ready.
  - On i_tx_ready && o_tx_valid with no new load, o_tx_valid clears.
- IDLE:
  - If any i_req_valid is high, winner = first set bit searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - grant_id <= winner; beat_cnt <= 0; next state is HEADER if HEADER_EN, else DATA.
  - IDLE arbitrates even while the output slot is draining.
- HEADER:
  - When slot_free, load {4'hA, grant_id[3:0]} and go to DATA.
  - o_req_ready stays 0 in HEADER.
- DATA:
  - o_req_ready[grant_id] = slot_free; all other bits 0.
  - On accept (valid && ready), load the byte and increment beat_cnt.
  - If the accepted beat has i_req_last, or beat_cnt == MAX_BURST-1: go to IDLE and set rr_ptr <= grant_id+1 (wraps at NUM_REQ).
  - A granted requester that drops valid mid-packet keeps the grant; the arbiter waits with no timeout.
- Latency, HEADER_EN=1, sink always ready: valid at cycle 0 → header on o_tx at cycle 2 → first data byte on o_tx at cycle 3 → one byte per cycle after that. With HEADER_EN=0 the first data byte appears at cycle 2.
- Back-to-back: after a burst ends, the next grant needs one IDLE cycle. Bubbles between bursts are allowed.
- Simultaneous requests: strict round-robin from rr_ptr. A single requester streaming more than MAX_BURST bytes is re-granted after IDLE, and gets a new header.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and grant_id are $clog2(NUM_REQ) bits, with explicit wrap when NUM_REQ is not a power of two.
- Invariants:
  - o_req_ready is never high in IDLE or HEADER.
  - At most one bit of o_req_ready is high.
  - o_tx_data is stable while o_tx_valid && !i_tx_ready.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_e enum: IDLE, HEADER, DATA.
  - HDR_TAG = 4'hA.
  - Function hdr_byte(id).
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs winner index and any_req. It is reused by the future RX demultiplexer.

Test Plan:
- Single requester: r1 sends 3-byte packet 0x11,0x22,0x33 (last on 0x33), sink always ready → o_tx stream 0xA1,0x11,0x22,0x33; header at cycle 2; return to IDLE; rr_ptr=2.
- Contention: r0..r3 all valid with 2-byte packets, rr_ptr=0 → headers in order 0xA0,0xA1,0xA2,0xA3; each followed by its own 2 bytes; no interleaving.
- Burst cap: MAX_BURST=16; r2 streams 20 bytes with last on byte 20 → 0xA2, 16 bytes, 0xA2, 4 bytes; other requesters are not starved if valid.
- Backpressure: i_tx_ready held low for 5 cycles mid-burst → o_tx_data and o_tx_valid stable; o_req_ready low; no byte lost or duplicated.
- HEADER_EN=0, r3 alone sends 0x5A with last → o_tx shows only 0x5A at cycle 2.
- Async reset asserted mid-burst (after 2 of 4 bytes) → all outputs 0 immediately. After release, a new r0 request yields fresh 0xA0 and its data with no leftover bytes.
